// File: rtl/cmd_frame_master_if.sv
// Request, UART TX/RX and response signals of the command frame master.
// Master modport is the frame master; slave modport is the host/UART side.
interface cmd_frame_master_if #(
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic [1:0]               req_cmd;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic [7:0]               req_wdata;
    logic [7:0]               req_opb;
    logic [ALU_FUN_WIDTH-1:0] req_fun;
    logic [7:0]               tx_data;
    logic                     tx_vld;
    logic                     tx_busy;
    logic [7:0]               rx_p_data;
    logic                     rx_d_vld;
    logic [15:0]              rsp_data;
    logic                     rsp_valid;
    logic                     rsp_timeout;
    logic                     busy;

    modport master (
        input  req_valid, req_cmd, req_addr, req_wdata, req_opb, req_fun,
        input  tx_busy, rx_p_data, rx_d_vld,
        output req_ready, tx_data, tx_vld, rsp_data, rsp_valid, rsp_timeout, busy
    );

    modport slave (
        output req_valid, req_cmd, req_addr, req_wdata, req_opb, req_fun,
        output tx_busy, rx_p_data, rx_d_vld,
        input  req_ready, tx_data, tx_vld, rsp_data, rsp_valid, rsp_timeout, busy
    );
endinterface

// File: rtl/cmd_frame_master.sv
// Serializes one UART command frame, collects 0-2 response bytes; TX stalls while tx_busy.
// Optional response timeout: define CMD_MASTER_TIMEOUT_EN.
module cmd_frame_master #(
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int RSP_TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    cmd_frame_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

    localparam logic [1:0] CMD_RF_WR = 2'b00;
    localparam logic [1:0] CMD_RF_RD = 2'b01;
    localparam logic [1:0] CMD_ALU_OP = 2'b10;

    state_t                   state;
    logic [1:0]               cmd_r;
    logic [ADDR_WIDTH-1:0]    addr_r;
    logic [7:0]               wdata_r;
    logic [7:0]               opb_r;
    logic [ALU_FUN_WIDTH-1:0] fun_r;
    logic [1:0]               idx;
    logic                     rx_cnt;
    logic [7:0]               tx_data_r;
    logic                     tx_vld_r;
    logic [15:0]              rsp_data_r;
    logic                     rsp_valid_r;

    function automatic logic [7:0] header(input logic [1:0] cmd);
        case (cmd)
            2'b00:   header = 8'hAA;
            2'b01:   header = 8'hBB;
            2'b10:   header = 8'hCC;
            default: header = 8'hDD;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] cmd);
        case (cmd)
            2'b00:   last_idx = 2'd2;
            2'b10:   last_idx = 2'd3;
            default: last_idx = 2'd1;
        endcase
    endfunction

    // Payload bytes come from the registered request; the header is loaded at capture.
    function automatic logic [7:0] payload(input logic [1:0] i);
        logic [7:0] addr_ext;
        logic [7:0] fun_ext;
        addr_ext = 8'(addr_r);
        fun_ext  = 8'(fun_r);
        payload  = 8'h00;
        case (i)
            2'd1: case (cmd_r)
                2'b00, 2'b01: payload = addr_ext;
                2'b10:        payload = wdata_r;
                default:      payload = fun_ext;
            endcase
            2'd2: payload = (cmd_r == CMD_ALU_OP) ? opb_r : wdata_r;
            2'd3: payload = fun_ext;
            default: payload = header(cmd_r);
        endcase
    endfunction

`ifdef CMD_MASTER_TIMEOUT_EN
    // Expiry when the count would reach RSP_TIMEOUT idle cycles.
    localparam logic [7:0] TO_LAST = 8'(RSP_TIMEOUT - 1);
    logic [7:0] to_cnt;
    logic       rsp_timeout_r;
    assign bus.rsp_timeout = rsp_timeout_r;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_r       <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            opb_r       <= '0;
            fun_r       <= '0;
            idx         <= '0;
            rx_cnt      <= 1'b0;
            tx_data_r   <= '0;
            tx_vld_r    <= 1'b0;
            rsp_data_r  <= '0;
            rsp_valid_r <= 1'b0;
`ifdef CMD_MASTER_TIMEOUT_EN
            to_cnt        <= '0;
            rsp_timeout_r <= 1'b0;
`endif
        end else begin
            rsp_valid_r <= 1'b0;
`ifdef CMD_MASTER_TIMEOUT_EN
            rsp_timeout_r <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cmd_r     <= bus.req_cmd;
                        addr_r    <= bus.req_addr;
                        wdata_r   <= bus.req_wdata;
                        opb_r     <= bus.req_opb;
                        fun_r     <= bus.req_fun;
                        idx       <= 2'd0;
                        rx_cnt    <= 1'b0;
                        tx_data_r <= header(bus.req_cmd);
                        tx_vld_r  <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (!bus.tx_busy) begin
                        if (idx == last_idx(cmd_r)) begin
                            tx_vld_r <= 1'b0;
                            if (cmd_r == CMD_RF_WR) begin
                                rsp_data_r  <= '0;
                                rsp_valid_r <= 1'b1;
                                state       <= IDLE;
                            end else begin
                                state <= WAIT_RSP;
                            end
`ifdef CMD_MASTER_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                        end else begin
                            idx       <= idx + 2'd1;
                            tx_data_r <= payload(idx + 2'd1);
                        end
                    end
                end
                WAIT_RSP: begin
                    if (bus.rx_d_vld) begin
`ifdef CMD_MASTER_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (!rx_cnt) begin
                            rsp_data_r <= {8'h00, bus.rx_p_data};
                            rx_cnt     <= 1'b1;
                            if (cmd_r == CMD_RF_RD) begin
                                rsp_valid_r <= 1'b1;
                                state       <= IDLE;
                            end
                        end else begin
                            rsp_data_r[15:8] <= bus.rx_p_data;
                            rsp_valid_r      <= 1'b1;
                            state            <= IDLE;
                        end
`ifdef CMD_MASTER_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        rsp_timeout_r <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_vld    = tx_vld_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_valid = rsp_valid_r;
endmodule

// File: tb/tb_cmd_frame_master.sv
// Directed scoreboard bench for cmd_frame_master: TX bytes and responses checked by a monitor.
module tb_cmd_frame_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_frame_master_if #(.ADDR_WIDTH(4), .ALU_FUN_WIDTH(4)) bus();

    cmd_frame_master #(.ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .RSP_TIMEOUT(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0]  exp_tx[$];
    logic [16:0] exp_rsp[$];   // bit 16 set: timeout pulse expected
    logic [16:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_vld && !bus.tx_busy) begin
                if (exp_tx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected: got %0h expected none", bus.tx_data);
                end else begin
                    chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, exp_tx.pop_front()});
                end
            end
            if (bus.rsp_valid || bus.rsp_timeout) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got valid=%0b timeout=%0b data=%0h expected none",
                             bus.rsp_valid, bus.rsp_timeout, bus.rsp_data);
                end else begin
                    mon_e = exp_rsp.pop_front();
                    chk("rsp_timeout_flag", {31'h0, bus.rsp_timeout}, {31'h0, mon_e[16]});
                    chk("rsp_valid_flag", {31'h0, bus.rsp_valid}, {31'h0, ~mon_e[16]});
                    chk("rsp_data", {16'h0, bus.rsp_data}, {16'h0, mon_e[15:0]});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] wdata,
                         input logic [7:0] opb, input logic [3:0] fun);
        step();
        chk("req_ready_before", {31'h0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_opb   = opb;
        bus.req_fun   = fun;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while (bus.tx_vld && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL tx_done_wait: got tx_vld still high expected low within 50 cycles");
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.rx_p_data = b;
        bus.rx_d_vld  = 1'b1;
        step();
        bus.rx_d_vld  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_tx.size() != 0) && n < 100) begin
            step();
            n++;
        end
        chk(name, exp_tx.size() + exp_rsp.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_opb = '0; bus.req_fun = '0; bus.tx_busy = 1'b0;
        bus.rx_p_data = '0; bus.rx_d_vld = 1'b0;
        #12;
        chk("rst_tx_vld", {31'h0, bus.tx_vld}, 32'd0);
        chk("rst_tx_data", {24'h0, bus.tx_data}, 32'd0);
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        chk("rst_busy", {31'h0, bus.busy}, 32'd0);
        chk("rst_rsp_data", {16'h0, bus.rsp_data}, 32'd0);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_timeout", {31'h0, bus.rsp_timeout}, 32'd0);
        step();
        rst_n = 1'b1;

        // RF write: three back-to-back TX cycles, completion in the fourth
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h03); exp_tx.push_back(8'h5A);
        exp_rsp.push_back({1'b0, 16'h0000});
        issue(2'b00, 4'h3, 8'h5A, 8'h00, 4'h0);
        for (int i = 0; i < 3; i++) begin
            chk("wr_tx_vld_run", {31'h0, bus.tx_vld}, 32'd1);
            step();
        end
        chk("wr_tx_vld_fall", {31'h0, bus.tx_vld}, 32'd0);
        chk("wr_rsp_valid_lat", {31'h0, bus.rsp_valid}, 32'd1);
        chk("wr_req_ready_back", {31'h0, bus.req_ready}, 32'd1);
        step();
        chk("wr_rsp_valid_pulse", {31'h0, bus.rsp_valid}, 32'd0);
        drain("wr_drain");

        // RF read with TX backpressure on the header byte
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h02);
        exp_rsp.push_back({1'b0, 16'h007E});
        bus.tx_busy = 1'b1;
        issue(2'b01, 4'h2, 8'h00, 8'h00, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk("rd_hold_data", {24'h0, bus.tx_data}, 32'hBB);
            chk("rd_hold_vld", {31'h0, bus.tx_vld}, 32'd1);
            step();
        end
        bus.tx_busy = 1'b0;
        wait_tx_done();
        chk("rd_busy_wait", {31'h0, bus.busy}, 32'd1);
        rx_byte(8'h7E);
        drain("rd_drain");

        // ALU with operands
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h10);
        exp_tx.push_back(8'h20); exp_tx.push_back(8'h01);
        exp_rsp.push_back({1'b0, 16'h0030});
        issue(2'b10, 4'h0, 8'h10, 8'h20, 4'h1);
        wait_tx_done();
        rx_byte(8'h30);
        rx_byte(8'h00);
        drain("aluop_drain");

        // ALU without operands, stray RX strobes during SEND incl. the final accept cycle
        exp_tx.push_back(8'hDD); exp_tx.push_back(8'h02);
        exp_rsp.push_back({1'b0, 16'h0200});
        issue(2'b11, 4'h0, 8'h00, 8'h00, 4'h2);
        bus.rx_p_data = 8'h55;
        bus.rx_d_vld  = 1'b1;
        step();
        step();
        bus.rx_d_vld  = 1'b0;
        chk("alunop_tx_done", {31'h0, bus.tx_vld}, 32'd0);
        rx_byte(8'h00);
        rx_byte(8'h02);
        drain("alunop_drain");
        repeat (3) step();
        chk("rsp_data_hold", {16'h0, bus.rsp_data}, 32'h0200);

`ifdef CMD_MASTER_TIMEOUT_EN
        // No response: timeout pulse exactly 10 cycles after entering WAIT_RSP
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h05);
        exp_rsp.push_back({1'b1, 16'h0200});
        issue(2'b01, 4'h5, 8'h00, 8'h00, 4'h0);
        wait_tx_done();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("to_pulse_cycle", {31'h0, bus.rsp_timeout}, (k == 10) ? 32'd1 : 32'd0);
        end
        step();
        chk("to_pulse_width", {31'h0, bus.rsp_timeout}, 32'd0);
        chk("to_idle", {31'h0, bus.busy}, 32'd0);
        drain("to_drain");

        // Byte arriving on the expiry cycle wins
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h06);
        exp_rsp.push_back({1'b0, 16'h003C});
        issue(2'b01, 4'h6, 8'h00, 8'h00, 4'h0);
        wait_tx_done();
        repeat (9) step();
        rx_byte(8'h3C);
        chk("to_race_valid", {31'h0, bus.rsp_valid}, 32'd1);
        chk("to_race_timeout", {31'h0, bus.rsp_timeout}, 32'd0);
        drain("to_race_drain");
`endif

        // Reset in the middle of an ALU frame
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h11);
        issue(2'b10, 4'h0, 8'h11, 8'h22, 4'h3);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_consumed", exp_tx.size(), 32'd0);
        chk("mid_rst_tx_vld", {31'h0, bus.tx_vld}, 32'd0);
        chk("mid_rst_tx_data", {24'h0, bus.tx_data}, 32'd0);
        chk("mid_rst_busy", {31'h0, bus.busy}, 32'd0);
        chk("mid_rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        chk("mid_rst_rsp_data", {16'h0, bus.rsp_data}, 32'd0);
        chk("mid_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        exp_tx.delete();
        exp_rsp.delete();
        repeat (2) step();
        rst_n = 1'b1;
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h0F); exp_tx.push_back(8'hA5);
        exp_rsp.push_back({1'b0, 16'h0000});
        issue(2'b00, 4'hF, 8'hA5, 8'h00, 4'h0);
        drain("post_rst_drain");

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
